// File: rtl/res_station_if.sv
// Reservation-station bus: dispatch, four scheduler read ports, two issue ports,
// retire broadcast and flush. master = rename/scheduler side, slave = station.
interface res_station_if #(
  parameter int RS_DEPTH = 16,
  parameter int CELL_W   = 95,
  parameter int ROB_W    = 6,
  parameter int DATA_W   = 32
);
  localparam int AW = $clog2(RS_DEPTH);
  localparam int OW = AW + 1;

  logic              flush;
  logic              disp_en;
  logic [CELL_W-1:0] disp_cell;
  logic              disp_ready;
  logic              full;
  logic [OW-1:0]     occupancy;
  logic [AW-1:0]     rd1_addr, rd2_addr, rd3_addr, rd4_addr;
  logic [CELL_W-1:0] rd1_cell, rd2_cell, rd3_cell, rd4_cell;
  logic              issue1_en, issue2_en;
  logic [AW-1:0]     issue1_addr, issue2_addr;
  logic              retire_en;
  logic [ROB_W-1:0]  retire_rob_addr;
  logic [DATA_W-1:0] retire_value;

  modport master (
    output flush, disp_en, disp_cell,
    output rd1_addr, rd2_addr, rd3_addr, rd4_addr,
    output issue1_en, issue2_en, issue1_addr, issue2_addr,
    output retire_en, retire_rob_addr, retire_value,
    input  disp_ready, full, occupancy,
    input  rd1_cell, rd2_cell, rd3_cell, rd4_cell
  );

  modport slave (
    input  flush, disp_en, disp_cell,
    input  rd1_addr, rd2_addr, rd3_addr, rd4_addr,
    input  issue1_en, issue2_en, issue1_addr, issue2_addr,
    input  retire_en, retire_rob_addr, retire_value,
    output disp_ready, full, occupancy,
    output rd1_cell, rd2_cell, rd3_cell, rd4_cell
  );
endinterface

// File: rtl/res_station.sv
// Reservation station: lowest-free-slot dispatch, retire wakeup, dual issue, 4 async reads.
// Optional macro QU_RS_DISPATCH_BYPASS_EN applies the wakeup compare to the cell being dispatched.
module res_station #(
  parameter int RS_DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  res_station_if.slave rs_if
);
  localparam int AW = $clog2(RS_DEPTH);
  localparam int OW = AW + 1;

  typedef logic [AW-1:0] res_st_addr_t;
  typedef logic [5:0]    rob_addr_t;
  typedef logic [31:0]   phy_rf_data_t;

  typedef struct packed {
    logic [15:0]  ctrl;
    phy_rf_data_t rs2_value;
    rob_addr_t    rs2_tag;
    logic         rs2_ready;
    phy_rf_data_t rs1_value;
    rob_addr_t    rs1_tag;
    logic         rs1_ready;
    logic         valid;
  } res_st_cell_t;

  function automatic res_st_cell_t wake(input res_st_cell_t c, input logic en,
                                        input rob_addr_t tag, input phy_rf_data_t val);
    res_st_cell_t r;
    r = c;
    if (en && !c.rs1_ready && c.rs1_tag == tag) begin
      r.rs1_ready = 1'b1;
      r.rs1_value = val;
    end
    if (en && !c.rs2_ready && c.rs2_tag == tag) begin
      r.rs2_ready = 1'b1;
      r.rs2_value = val;
    end
    return r;
  endfunction

  res_st_cell_t        w_cells [RS_DEPTH];
  res_st_cell_t        w_disp_cell;
  res_st_cell_t        w_disp_store;
  logic                w_disp_acc;
  res_st_addr_t        w_free_idx;
  logic [RS_DEPTH-1:0] w_hit;
  logic [RS_DEPTH-1:0] w_freed;
  logic [OW-1:0]       w_nfreed;
  logic [OW-1:0]       w_occ_next;
  logic [OW-1:0]       r_occ;
  logic                r_full;

  always_comb begin
    w_disp_cell       = res_st_cell_t'(rs_if.disp_cell);
    w_disp_cell.valid = 1'b1;
  end

`ifdef QU_RS_DISPATCH_BYPASS_EN
  assign w_disp_store = wake(w_disp_cell, rs_if.retire_en, rs_if.retire_rob_addr, rs_if.retire_value);
`else
  assign w_disp_store = w_disp_cell;
`endif

  // Registered valid bits only: a slot freed this cycle is not a dispatch target until next cycle.
  always_comb begin
    w_free_idx = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (!w_cells[i].valid) w_free_idx = res_st_addr_t'(i);
    end
  end

  assign w_disp_acc = rs_if.disp_en && !r_full && rs_if.disp_cell[0];

  for (genvar gi = 0; gi < RS_DEPTH; gi++) begin : g_ent
    localparam res_st_addr_t IDX = res_st_addr_t'(gi);
    res_st_cell_t r_cell;

    assign w_hit[gi]   = (rs_if.issue1_en && rs_if.issue1_addr == IDX) ||
                         (rs_if.issue2_en && rs_if.issue2_addr == IDX);
    assign w_freed[gi] = w_hit[gi] && r_cell.valid;
    assign w_cells[gi] = r_cell;

    always_ff @(posedge clk) begin
      if (rst || rs_if.flush) begin
        r_cell <= '0;
      end else if (w_disp_acc && w_free_idx == IDX) begin
        r_cell <= w_disp_store;
      end else if (w_freed[gi]) begin
        r_cell.valid <= 1'b0;
      end else if (r_cell.valid) begin
        r_cell <= wake(r_cell, rs_if.retire_en, rs_if.retire_rob_addr, rs_if.retire_value);
      end
    end
  end

  always_comb begin
    w_nfreed = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      w_nfreed = w_nfreed + OW'(w_freed[i]);
    end
    w_occ_next = r_occ + OW'(w_disp_acc) - w_nfreed;
  end

  always_ff @(posedge clk) begin
    if (rst || rs_if.flush) begin
      r_occ  <= '0;
      r_full <= 1'b0;
    end else begin
      assert ((r_occ + OW'(w_disp_acc)) >= w_nfreed);
      r_occ  <= w_occ_next;
      r_full <= (w_occ_next == OW'(RS_DEPTH));
    end
  end

  assign rs_if.occupancy  = r_occ;
  assign rs_if.full       = r_full;
  assign rs_if.disp_ready = !r_full;
  assign rs_if.rd1_cell   = w_cells[rs_if.rd1_addr];
  assign rs_if.rd2_cell   = w_cells[rs_if.rd2_addr];
  assign rs_if.rd3_cell   = w_cells[rs_if.rd3_addr];
  assign rs_if.rd4_cell   = w_cells[rs_if.rd4_addr];
endmodule
